// File: rtl/biquad_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade.
package biquad_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam logic [2:0] K_B0 = 3'd0;
   localparam logic [2:0] K_B1 = 3'd1;
   localparam logic [2:0] K_B2 = 3'd2;
   localparam logic [2:0] K_A1 = 3'd3;
   localparam logic [2:0] K_A2 = 3'd4;
   localparam int         TAPS = 5;

   // Five products summed into three guard bits can never overflow.
   function automatic int acc_w(input int coef_w, input int data_w);
      return coef_w + data_w + 3;
   endfunction

endpackage

// File: rtl/biquad_sat.sv
// Arithmetic right shift by FRAC_W (floor) followed by clamp to the DATA_W signed range.
module biquad_sat #(
   parameter int IN_W   = 31,
   parameter int DATA_W = 10,
   parameter int FRAC_W = 10
) (
   input  logic signed [IN_W-1:0]   acc,
   output logic signed [DATA_W-1:0] result
);

   localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] MINV = {{(IN_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   function automatic logic signed [DATA_W-1:0] shift_sat(input logic signed [IN_W-1:0] v);
      logic signed [IN_W-1:0] sh;
      sh = v >>> FRAC_W;
      if (sh > MAXV)
         return MAXV[DATA_W-1:0];
      else if (sh < MINV)
         return MINV[DATA_W-1:0];
      else
         return sh[DATA_W-1:0];
   endfunction

   assign result = shift_sat(acc);

endmodule

// File: rtl/biquad_cascade.sv
// Cascade of SECTIONS direct-form-I biquads sharing one signed MAC; one sample in flight,
// 5 MAC cycles plus one write-back cycle per section.
module biquad_cascade
   import biquad_pkg::*;
#(
   parameter int DATA_W   = 10,
   parameter int COEF_W   = 18,
   parameter int FRAC_W   = 10,
   parameter int SECTIONS = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic signed [DATA_W-1:0]             in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic signed [DATA_W-1:0]             out_data,
   output logic                                 out_valid,
   input  logic                                 coef_we,
   input  logic [$clog2(TAPS*SECTIONS)-1:0]     coef_addr,
   input  logic signed [COEF_W-1:0]             coef_data
);

   localparam int NCOEF  = TAPS * SECTIONS;
   localparam int AW     = $clog2(NCOEF);
   localparam int SW     = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
   localparam int PROD_W = COEF_W + DATA_W;
   localparam int ACC_W  = acc_w(COEF_W, DATA_W);
   localparam logic [AW:0] NCOEF_V = (AW+1)'(NCOEF);

   state_t state, state_next;
   logic [2:0]    k;
   logic [SW-1:0] sec;
   logic          last_tap, last_sec, accept, coef_ok;

   logic signed [COEF_W-1:0] coef_mem [NCOEF];
   logic signed [DATA_W-1:0] x1 [SECTIONS];
   logic signed [DATA_W-1:0] x2 [SECTIONS];
   logic signed [DATA_W-1:0] y1 [SECTIONS];
   logic signed [DATA_W-1:0] y2 [SECTIONS];

   logic signed [DATA_W-1:0] x_cur;
   logic signed [DATA_W-1:0] operand;
   logic signed [COEF_W-1:0] coef_cur;
   logic [AW-1:0]            coef_idx;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] result;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign coef_ok  = coef_we && ({1'b0, coef_addr} < NCOEF_V);
   assign last_tap = (k == K_A2);
   assign last_sec = (sec == SW'(SECTIONS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = MAC;
         MAC:     if (last_tap) state_next = WB;
         WB:      state_next = last_sec ? IDLE : MAC;
         default: state_next = IDLE;
      endcase
   end

   // Operand order matches the coefficient order b0, b1, b2, a1, a2 within a section.
   always_comb begin
      operand = x_cur;
      case (k)
         K_B0:    operand = x_cur;
         K_B1:    operand = x1[sec];
         K_B2:    operand = x2[sec];
         K_A1:    operand = y1[sec];
         K_A2:    operand = y2[sec];
         default: operand = x_cur;
      endcase
   end

   assign coef_idx = AW'(TAPS * int'(sec) + int'(k));
   assign coef_cur = coef_mem[coef_idx];
   assign prod     = coef_cur * operand;
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

   biquad_sat #(
      .IN_W   (ACC_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_sat (
      .acc    (acc),
      .result (result)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k         <= '0;
         sec       <= '0;
         acc       <= '0;
         x_cur     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < NCOEF; i++)
            coef_mem[i] <= '0;
         for (int i = 0; i < SECTIONS; i++) begin
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (coef_ok)
                  coef_mem[coef_addr] <= coef_data;
               if (accept) begin
                  x_cur <= in_data;
                  acc   <= '0;
                  sec   <= '0;
                  k     <= '0;
               end
            end
            MAC: begin
               acc <= acc + prod_ext;
               k   <= k + 3'd1;
            end
            WB: begin
               // The section output becomes the next section's input.
               x2[sec] <= x1[sec];
               x1[sec] <= x_cur;
               y2[sec] <= y1[sec];
               y1[sec] <= result;
               x_cur   <= result;
               acc     <= '0;
               k       <= '0;
               if (last_sec) begin
                  out_data  <= result;
                  out_valid <= 1'b1;
               end else begin
                  sec <= sec + SW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_biquad_cascade.sv
// Directed scoreboard bench for biquad_cascade at default parameters.
module tb_biquad_cascade;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic signed [9:0]  in_data = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [9:0]  out_data;
   logic               out_valid;
   logic               coef_we = 1'b0;
   logic [3:0]         coef_addr = '0;
   logic signed [17:0] coef_data = '0;

   int checks = 0;
   int failures = 0;
   int stim_q[$];
   int model_q[$];
   int exp_q[$];
   int drv_q[$];

   biquad_cascade #(
      .DATA_W   (10),
      .COEF_W   (18),
      .FRAC_W   (10),
      .SECTIONS (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic write_coef(input int addr, input int val);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 4'(addr);
      coef_data = 18'(val);
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic add(input int din, input int exp);
      stim_q.push_back(din);
      model_q.push_back(exp);
   endtask

   // Drives queued samples as soon as in_ready allows; scores every out_valid pulse.
   task automatic run_stream(input string tag);
      int cyc = 0;
      int last_drv = -1;
      while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk({tag, "_unexpected"}, 1, 0);
            end else begin
               chk({tag, "_out"}, int'(out_data), exp_q.pop_front());
               chk({tag, "_lat"}, cyc - drv_q.pop_front(), 13);
            end
         end
         if (in_ready && stim_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = 10'(stim_q.pop_front());
            exp_q.push_back(model_q.pop_front());
            drv_q.push_back(cyc);
            if (last_drv >= 0)
               chk({tag, "_gap"}, cyc - last_drv, 13);
            last_drv = cyc;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk({tag, "_pending"}, exp_q.size(), 0);
      stim_q.delete();
      model_q.delete();
      exp_q.delete();
      drv_q.delete();
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 40);
      chk({tag, "_seen"}, int'(out_valid), 1);
      if (out_valid && exp_q.size() > 0)
         chk(tag, int'(out_data), exp_q.pop_front());
      exp_q.delete();
   endtask

   initial begin
      int pulses;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_in_ready", int'(in_ready), 1);

      add(100, 0);
      run_stream("zero_coef");

      do_reset();
      write_coef(0, 1024);
      write_coef(5, 1024);
      add(300, 300);
      add(-512, -512);
      add(511, 511);
      run_stream("pass");
      repeat (5) @(negedge clk);
      chk("hold_data", int'(out_data), 511);
      chk("hold_valid", int'(out_valid), 0);

      do_reset();
      write_coef(1, 1024);
      write_coef(5, 1024);
      add(5, 0);
      add(7, 5);
      add(9, 7);
      run_stream("delay");

      do_reset();
      write_coef(0, 4096);
      write_coef(5, 1024);
      add(200, 511);
      add(-200, -512);
      run_stream("sat");

      do_reset();
      write_coef(0, 1024);
      write_coef(3, 512);
      write_coef(5, 1024);
      add(-3, -3);
      add(0, -2);
      add(0, -1);
      add(0, -1);
      add(0, -1);
      run_stream("floor");

      do_reset();
      write_coef(0, 1024);
      write_coef(3, 512);
      write_coef(5, 1024);
      add(256, 256);
      add(0, 128);
      add(0, 64);
      run_stream("impulse");

      do_reset();
      write_coef(0, 1024);
      write_coef(5, 1024);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 10'sd300;
      exp_q.push_back(300);
      @(negedge clk);
      chk("busy_ready_c1", int'(in_ready), 0);
      in_data   = 10'sd77;
      coef_we   = 1'b1;
      coef_addr = 4'd0;
      coef_data = 18'sd2048;
      @(negedge clk);
      chk("busy_ready_c2", int'(in_ready), 0);
      coef_we  = 1'b0;
      in_valid = 1'b0;
      wait_out("busy_out");
      add(100, 100);
      run_stream("busy_after");

      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 10'sd200;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      chk("midrst_pulses", pulses, 0);
      chk("midrst_ready", int'(in_ready), 1);
      chk("midrst_data", int'(out_data), 0);
      write_coef(1, 1024);
      write_coef(5, 1024);
      add(9, 0);
      add(4, 9);
      run_stream("midrst_hist");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
